// File: rtl/pixel_scan_sequencer_pkg.sv
// Shared types and defaults for the pixel-matrix scan sequencer.
// Holds the FSM state encoding and the default geometry/timing parameters.
package pixel_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_REQ    = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } scan_state_e;

  localparam int ROW_DEF        = 400;
  localparam int COLUMN_DEF     = 32;
  localparam int DWELL_W_DEF    = 16;
  localparam int FRAME_W_DEF    = 16;
  localparam int TMO_CYCLES_DEF = 1024;

endpackage

// File: rtl/pixel_scan_sequencer_if.sv
// Scan-side handshake between the sequencer (master) and the scan/readout block (slave).
interface pixel_scan_sequencer_if;

  logic start_s;
  logic speak_s;
  logic sample_req;
  logic sample_ack;

  modport master (
    output start_s,
    output speak_s,
    output sample_req,
    input  sample_ack
  );

  modport slave (
    input  start_s,
    input  speak_s,
    input  sample_req,
    output sample_ack
  );

endinterface

// File: rtl/pixel_scan_sequencer_pos_tracker.sv
// Mirror of the scan block's column/row position, with a flag for the last pixel of a frame.
module scan_pos_tracker
  import pixel_scan_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COLUMN = COLUMN_DEF
) (
  input  logic                      clk_s,
  input  logic                      rstn_s,
  input  logic                      clr,
  input  logic                      step,
  output logic [$clog2(ROW)-1:0]    row_pos,
  output logic [$clog2(COLUMN)-1:0] col_pos,
  output logic                      last_pixel
);

  localparam int RW = $clog2(ROW);
  localparam int CW = $clog2(COLUMN);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMN - 1);

  assign last_pixel = (row_pos == ROW_LAST) && (col_pos == COL_LAST);

  // Column counter wraps into a row increment, row wraps to zero, exactly as the scan block does
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      row_pos <= '0;
      col_pos <= '0;
    end else if (clr) begin
      row_pos <= '0;
      col_pos <= '0;
    end else if (step) begin
      if (col_pos == COL_LAST) begin
        col_pos <= '0;
        row_pos <= (row_pos == ROW_LAST) ? '0 : row_pos + 1'b1;
      end else begin
        col_pos <= col_pos + 1'b1;
      end
    end else begin
      row_pos <= row_pos;
      col_pos <= col_pos;
    end
  end

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Pixel-matrix scan sequencer: start pulse, per-pixel dwell/sample/step, frame counting.
// Optional ack timeout enabled by defining SCAN_ACK_TIMEOUT_EN.
module pixel_scan_sequencer
  import pixel_scan_pkg::*;
#(
  parameter int ROW     = ROW_DEF,
  parameter int COLUMN  = COLUMN_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
`ifdef SCAN_ACK_TIMEOUT_EN
  , parameter int TMO_CYCLES = TMO_CYCLES_DEF
`endif
) (
  input  logic                      clk_s,
  input  logic                      rstn_s,
  input  logic                      run,
  input  logic                      abort,
  input  logic [DWELL_W-1:0]        cfg_dwell,
  input  logic [FRAME_W-1:0]        cfg_frames,
  pixel_scan_sequencer_if.master    scan,
  output logic [$clog2(ROW)-1:0]    row_pos,
  output logic [$clog2(COLUMN)-1:0] col_pos,
  output logic [FRAME_W-1:0]        frame_cnt,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      done,
  output logic                      ack_err
);

  scan_state_e          state_r;
  scan_state_e          state_nx_s;
  logic [DWELL_W-1:0]   cfg_dwell_r;
  logic [FRAME_W-1:0]   cfg_frames_r;
  logic [DWELL_W-1:0]   dwell_cnt_r;
  logic [FRAME_W-1:0]   frame_cnt_r;
  logic [DWELL_W:0]     dwell_tgt_s;
  logic                 run_go_s;
  logic                 step_s;
  logic                 last_pixel_s;
  logic                 dwell_done_s;
  logic                 frames_reached_s;
  logic                 tmo_hit_s;

  assign run_go_s = (state_r == ST_IDLE) && run && !abort;
  assign step_s   = (state_r == ST_STEP) && !abort;

  // A dwell of zero still spends one cycle in SETTLE
  assign dwell_tgt_s  = (cfg_dwell_r == '0) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, cfg_dwell_r};
  assign dwell_done_s = (({1'b0, dwell_cnt_r} + {{DWELL_W{1'b0}}, 1'b1}) == dwell_tgt_s);

  assign frames_reached_s = (cfg_frames_r != '0) &&
                            (({1'b0, frame_cnt_r} + {{FRAME_W{1'b0}}, 1'b1}) == {1'b0, cfg_frames_r});

  assign scan.start_s    = (state_r == ST_ARM) && !abort;
  assign scan.speak_s    = step_s;
  assign scan.sample_req = (state_r == ST_REQ) && !abort;
  assign busy            = (state_r != ST_IDLE);
  assign frame_done      = step_s && last_pixel_s;
  assign done            = (state_r == ST_DONE);
  assign frame_cnt       = frame_cnt_r;

  scan_pos_tracker #(
    .ROW    (ROW),
    .COLUMN (COLUMN)
  ) u_pos (
    .clk_s      (clk_s),
    .rstn_s     (rstn_s),
    .clr        (run_go_s),
    .step       (step_s),
    .row_pos    (row_pos),
    .col_pos    (col_pos),
    .last_pixel (last_pixel_s)
  );

  // State register
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nx_s = state_r;
    if (abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nx_s = run ? ST_ARM : ST_IDLE;
        ST_ARM:    state_nx_s = ST_SETTLE;
        ST_SETTLE: state_nx_s = dwell_done_s ? ST_REQ : ST_SETTLE;
        ST_REQ:    state_nx_s = (scan.sample_ack || tmo_hit_s) ? ST_STEP : ST_REQ;
        ST_STEP:   state_nx_s = (last_pixel_s && frames_reached_s) ? ST_DONE : ST_SETTLE;
        ST_DONE:   state_nx_s = ST_IDLE;
        default:   state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Configuration is captured only when a scan is launched
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      cfg_dwell_r  <= '0;
      cfg_frames_r <= '0;
    end else if (run_go_s) begin
      cfg_dwell_r  <= cfg_dwell;
      cfg_frames_r <= cfg_frames;
    end else begin
      cfg_dwell_r  <= cfg_dwell_r;
      cfg_frames_r <= cfg_frames_r;
    end
  end

  // Dwell counter: counts only while settling, otherwise parked at zero
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      dwell_cnt_r <= '0;
    end else if ((state_r == ST_SETTLE) && !abort && !dwell_done_s) begin
      dwell_cnt_r <= dwell_cnt_r + 1'b1;
    end else begin
      dwell_cnt_r <= '0;
    end
  end

  // Frame counter saturates so continuous mode never wraps back to zero
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      frame_cnt_r <= '0;
    end else if (run_go_s) begin
      frame_cnt_r <= '0;
    end else if (step_s && last_pixel_s && (frame_cnt_r != '1)) begin
      frame_cnt_r <= frame_cnt_r + 1'b1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

`ifdef SCAN_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_r;
  logic          ack_err_r;

  assign tmo_hit_s = (state_r == ST_REQ) && !scan.sample_ack && (tmo_cnt_r == TMO_LAST);
  assign ack_err   = ack_err_r;

  // Cycles spent waiting for ack in the current REQ visit
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_REQ) && !abort && !scan.sample_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset or a new run
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      ack_err_r <= 1'b0;
    end else if (run_go_s) begin
      ack_err_r <= 1'b0;
    end else if (tmo_hit_s && !abort) begin
      ack_err_r <= 1'b1;
    end else begin
      ack_err_r <= ack_err_r;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign ack_err   = 1'b0;
`endif

endmodule
